// File: rtl/irq_trap_sequencer.sv
// Trap/interrupt sequencer in front of the machine-mode CSR controller.
// Define IRQ_SEQ_EDGE_EN for edge-triggered pending interrupt lines.
module irq_trap_sequencer #(
    parameter int N_IRQ = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             exc_i,
    input  logic [4:0]       exc_cause_i,
    input  logic             ready_i,
    input  logic             mret_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      mie_i,
    input  logic [31:0]      mtvec_i,
    input  logic [31:0]      mepc_i,
    output logic             trap_o,
    output logic [31:0]      mcause_o,
    output logic [31:0]      epc_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [N_IRQ-1:0] irq_ack_o,
    output logic             gie_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TRAP,
        S_HANDLER,
        S_RETURN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_is_exc;
    logic [4:0]       r_cause;
    logic [3:0]       r_idx;
    logic [31:0]      r_epc_lat;
    logic             r_trap;
    logic [31:0]      r_mcause;
    logic [31:0]      r_epc;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic [N_IRQ-1:0] r_ack;
    logic             r_gie;
    logic             r_busy;

    logic [N_IRQ-1:0] w_src;
    logic [N_IRQ-1:0] w_elig;
    logic             w_any;
    logic [3:0]       w_sel;
    logic [N_IRQ-1:0] w_onehot;
    logic             w_take_exc;
    logic             w_take_irq;
    logic             w_fire;
    logic             w_ret;
    logic [4:0]       w_trap_cause;
    logic [31:0]      w_base;
    logic [31:0]      w_vec;
    logic [31:0]      w_target;
    logic             w_unused;

    assign w_unused = ^mie_i;

`ifdef IRQ_SEQ_EDGE_EN
    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] w_rise;

    assign w_rise = irq_i & ~r_prev;
    assign w_src  = r_pend;

    // A rising edge in the ack cycle keeps the bit set.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= irq_i;
            r_pend <= (r_pend & ~r_ack) | w_rise;
        end
    end
`else
    assign w_src = irq_i;
`endif

    assign w_elig = w_src & mie_i[16 +: N_IRQ] & {N_IRQ{r_gie}};

    // Fixed priority: lowest line index wins.
    always_comb begin
        w_any = 1'b0;
        w_sel = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_any = 1'b1;
                w_sel = 4'(i);
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_onehot[i] = (r_idx == 4'(i));
        end
    end

    assign w_trap_cause = r_is_exc ? r_cause : {1'b1, r_idx};
    assign w_base       = {mtvec_i[31:2], 2'b00};
    assign w_vec        = w_base + {25'b0, w_trap_cause, 2'b00};
    assign w_target     = (!r_is_exc && mtvec_i[1:0] == 2'b01) ? w_vec : w_base;

    always_comb begin
        w_next     = r_state;
        w_take_exc = 1'b0;
        w_take_irq = 1'b0;
        w_fire     = 1'b0;
        w_ret      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (exc_i) begin
                    w_take_exc = 1'b1;
                    w_next     = S_ARM;
                end else if (w_any) begin
                    w_take_irq = 1'b1;
                    w_next     = S_ARM;
                end
            end
            S_ARM: begin
                if (ready_i) begin
                    w_fire = 1'b1;
                    w_next = S_TRAP;
                end
            end
            S_TRAP: begin
                w_next = S_HANDLER;
            end
            S_HANDLER: begin
                if (exc_i) begin
                    w_take_exc = 1'b1;
                    w_next     = S_ARM;
                end else if (mret_i) begin
                    w_ret  = 1'b1;
                    w_next = S_RETURN;
                end
            end
            S_RETURN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= S_IDLE;
            r_is_exc      <= 1'b0;
            r_cause       <= 5'd0;
            r_idx         <= 4'd0;
            r_epc_lat     <= 32'd0;
            r_trap        <= 1'b0;
            r_mcause      <= 32'd0;
            r_epc         <= 32'd0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_ack         <= '0;
            r_gie         <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_busy     <= (w_next != S_IDLE);
            r_trap     <= w_fire;
            r_redirect <= w_fire | w_ret;
            r_ack      <= (w_fire && !r_is_exc) ? w_onehot : '0;
            if (w_take_exc) begin
                r_is_exc  <= 1'b1;
                r_cause   <= exc_cause_i;
                r_epc_lat <= pc_i;
            end
            if (w_take_irq) begin
                r_is_exc <= 1'b0;
                r_idx    <= w_sel;
            end
            // Exceptions report the PC captured with the fault.
            if (w_fire) begin
                r_mcause      <= {~r_is_exc, 26'b0, w_trap_cause};
                r_epc         <= r_is_exc ? r_epc_lat : pc_i;
                r_redirect_pc <= w_target;
                r_gie         <= 1'b0;
            end
            if (w_ret) begin
                r_redirect_pc <= mepc_i;
                r_gie         <= 1'b1;
            end
        end
    end

    assign trap_o        = r_trap;
    assign mcause_o      = r_mcause;
    assign epc_o         = r_epc;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign irq_ack_o     = r_ack;
    assign gie_o         = r_gie;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_irq_trap_sequencer.sv
// Self-checking bench for irq_trap_sequencer with a trap-level reference model.
// Handles both the level build and the IRQ_SEQ_EDGE_EN build.
module tb_irq_trap_sequencer;

`ifdef IRQ_SEQ_EDGE_EN
    localparam int LAT = 3;
    localparam bit EDGE = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit EDGE = 1'b0;
`endif

    logic        clk_i;
    logic        rst_i;
    logic [15:0] irq_i;
    logic        exc_i;
    logic [4:0]  exc_cause_i;
    logic        ready_i;
    logic        mret_i;
    logic [31:0] pc_i;
    logic [31:0] mie_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        trap_o;
    logic [31:0] mcause_o;
    logic [31:0] epc_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [15:0] irq_ack_o;
    logic        gie_o;
    logic        busy_o;

    int checks;
    int failures;

    irq_trap_sequencer #(.N_IRQ(16)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .irq_i        (irq_i),
        .exc_i        (exc_i),
        .exc_cause_i  (exc_cause_i),
        .ready_i      (ready_i),
        .mret_i       (mret_i),
        .pc_i         (pc_i),
        .mie_i        (mie_i),
        .mtvec_i      (mtvec_i),
        .mepc_i       (mepc_i),
        .trap_o       (trap_o),
        .mcause_o     (mcause_o),
        .epc_o        (epc_o),
        .redirect_o   (redirect_o),
        .redirect_pc_o(redirect_pc_o),
        .irq_ack_o    (irq_ack_o),
        .gie_o        (gie_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic int model_pick(input logic [15:0] irq, input logic [31:0] mie);
        for (int i = 0; i < 16; i++) begin
            if (irq[i] && mie[16+i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] mtvec,
                                                 input bit is_exc, input int line);
        logic [31:0] base;
        base = mtvec & 32'hFFFF_FFFC;
        if (!is_exc && (mtvec & 32'd3) == 32'd1) return base + 32'(4 * (16 + line));
        return base;
    endfunction

    task automatic do_reset();
        rst_i = 1'b0;
        irq_i = '0; exc_i = 1'b0; exc_cause_i = '0; ready_i = 1'b1;
        mret_i = 1'b0; pc_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic wait_trap(input int max, output int n);
        n = -1;
        for (int k = 1; k <= max; k++) begin
            @(negedge clk_i);
            if (trap_o === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_mret(input logic [31:0] mepc);
        mret_i = 1'b1;
        mepc_i = mepc;
        @(negedge clk_i);
        mret_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        irq_i = '0; exc_i = 1'b0; exc_cause_i = '0; ready_i = 1'b1;
        mret_i = 1'b0; pc_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;
        repeat (2) @(negedge clk_i);
        checks++; if (trap_o !== 1'b0) begin failures++; $display("FAIL rst_trap got=%b exp=0", trap_o); end
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%b exp=0", redirect_o); end
        checks++; if (gie_o !== 1'b1) begin failures++; $display("FAIL rst_gie got=%b exp=1", gie_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        checks++; if (irq_ack_o !== 16'h0) begin failures++; $display("FAIL rst_ack got=%h exp=0", irq_ack_o); end
        checks++; if (mcause_o !== 32'h0) begin failures++; $display("FAIL rst_mcause got=%h exp=0", mcause_o); end
        checks++; if (epc_o !== 32'h0) begin failures++; $display("FAIL rst_epc got=%h exp=0", epc_o); end
        checks++; if (redirect_pc_o !== 32'h0) begin failures++; $display("FAIL rst_rpc got=%h exp=0", redirect_pc_o); end
        rst_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_basic_irq();
        int n;
        do_reset();
        mie_i = 32'h0008_0000; mtvec_i = 32'h1000_0000; pc_i = 32'h400;
        irq_i = 16'h0008;
        wait_trap(8, n);
        checks++; if (n != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (mcause_o !== 32'h8000_0013) begin failures++; $display("FAIL basic_mcause got=%h exp=80000013", mcause_o); end
        checks++; if (irq_ack_o !== 16'h0008) begin failures++; $display("FAIL basic_ack got=%h exp=0008", irq_ack_o); end
        checks++; if (redirect_pc_o !== 32'h1000_0000) begin failures++; $display("FAIL basic_rpc got=%h exp=10000000", redirect_pc_o); end
        checks++; if (gie_o !== 1'b0) begin failures++; $display("FAIL basic_gie got=%b exp=0", gie_o); end
        checks++; if (epc_o !== 32'h400) begin failures++; $display("FAIL basic_epc got=%h exp=400", epc_o); end
        checks++; if (redirect_o !== 1'b1) begin failures++; $display("FAIL basic_redirect got=%b exp=1", redirect_o); end
        irq_i = '0;
        @(negedge clk_i);
        checks++; if (trap_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL basic_handler got=%b%b exp=01", trap_o, busy_o); end
    endtask

    task automatic test_priority();
        int n;
        do_reset();
        mie_i = 32'hFFFF_0000; mtvec_i = 32'h0000_0800;
        irq_i = 16'h0024;
        wait_trap(8, n);
        checks++; if (n != LAT) begin failures++; $display("FAIL prio_latency got=%0d exp=%0d", n, LAT); end
        checks++; if (mcause_o !== 32'h8000_0012) begin failures++; $display("FAIL prio_mcause got=%h exp=80000012", mcause_o); end
        checks++; if (irq_ack_o !== 16'h0004) begin failures++; $display("FAIL prio_ack got=%h exp=0004", irq_ack_o); end
        @(negedge clk_i);
        irq_i = 16'h0020;
        do_mret(32'h200);
        checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200) begin failures++; $display("FAIL prio_ret got=%b/%h exp=1/200", redirect_o, redirect_pc_o); end
        wait_trap(6, n);
        checks++; if (n != 3) begin failures++; $display("FAIL prio_second_latency got=%0d exp=3", n); end
        checks++; if (mcause_o !== 32'h8000_0015) begin failures++; $display("FAIL prio_second_mcause got=%h exp=80000015", mcause_o); end
        checks++; if (irq_ack_o !== 16'h0020) begin failures++; $display("FAIL prio_second_ack got=%h exp=0020", irq_ack_o); end
        irq_i = '0;
    endtask

    task automatic test_exception();
        int n;
        do_reset();
        mie_i = 32'h0001_0000; mtvec_i = 32'h0000_1001;
        exc_i = 1'b1; exc_cause_i = 5'd2; irq_i = 16'h0001; pc_i = 32'h500;
        @(negedge clk_i);
        exc_i = 1'b0; pc_i = 32'h9990;
        wait_trap(6, n);
        checks++; if (n != 1) begin failures++; $display("FAIL exc_latency got=%0d exp=1", n); end
        checks++; if (mcause_o !== 32'h0000_0002) begin failures++; $display("FAIL exc_mcause got=%h exp=00000002", mcause_o); end
        checks++; if (redirect_pc_o !== 32'h1000) begin failures++; $display("FAIL exc_rpc got=%h exp=1000", redirect_pc_o); end
        checks++; if (epc_o !== 32'h500) begin failures++; $display("FAIL exc_epc got=%h exp=500", epc_o); end
        checks++; if (irq_ack_o !== 16'h0) begin failures++; $display("FAIL exc_ack got=%h exp=0", irq_ack_o); end
        irq_i = '0;
    endtask

    task automatic test_vectored_ready();
        int cnt;
        bit early;
        do_reset();
        mie_i = 32'h0002_0000; mtvec_i = 32'h0000_2001; ready_i = 1'b0; pc_i = 32'h111;
        irq_i = 16'h0002;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            cnt++;
            if (busy_o === 1'b1) break;
        end
        checks++; if (cnt != LAT - 1) begin failures++; $display("FAIL vec_arm got=%0d exp=%0d", cnt, LAT - 1); end
        early = 1'b0;
        repeat (5) begin
            @(negedge clk_i);
            cnt++;
            if (trap_o !== 1'b0) early = 1'b1;
        end
        checks++; if (early) begin failures++; $display("FAIL vec_stall got=trap exp=none"); end
        ready_i = 1'b1; pc_i = 32'hABC0;
        @(negedge clk_i);
        cnt++;
        checks++; if (trap_o !== 1'b1 || cnt != LAT + 5) begin failures++; $display("FAIL vec_trap got=%b@%0d exp=1@%0d", trap_o, cnt, LAT + 5); end
        checks++; if (redirect_pc_o !== 32'h2044) begin failures++; $display("FAIL vec_rpc got=%h exp=2044", redirect_pc_o); end
        checks++; if (epc_o !== 32'hABC0) begin failures++; $display("FAIL vec_epc got=%h exp=abc0", epc_o); end
        checks++; if (mcause_o !== 32'h8000_0011) begin failures++; $display("FAIL vec_mcause got=%h exp=80000011", mcause_o); end
        irq_i = '0;
    endtask

    task automatic test_handler();
        int n;
        bit bad;
        do_reset();
        mie_i = 32'hFFFF_0000; mtvec_i = 32'h0000_3000;
        irq_i = 16'h0080;
        wait_trap(8, n);
        checks++; if (n != LAT) begin failures++; $display("FAIL hdl_latency got=%0d exp=%0d", n, LAT); end
        irq_i = '0;
        @(negedge clk_i);
        irq_i = 16'h0001;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk_i);
            if (trap_o !== 1'b0 || busy_o !== 1'b1 || gie_o !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL hdl_masked got=trap_or_state exp=quiet"); end
        exc_i = 1'b1; exc_cause_i = 5'd7; mret_i = 1'b1; mepc_i = 32'h100; pc_i = 32'h77C;
        @(negedge clk_i);
        exc_i = 1'b0; mret_i = 1'b0;
        checks++; if (redirect_o !== 1'b0) begin failures++; $display("FAIL hdl_exc_wins got=%b exp=0", redirect_o); end
        wait_trap(4, n);
        checks++; if (n != 1 || mcause_o !== 32'h7) begin failures++; $display("FAIL hdl_exc_trap got=%0d/%h exp=1/00000007", n, mcause_o); end
        checks++; if (epc_o !== 32'h77C) begin failures++; $display("FAIL hdl_exc_epc got=%h exp=77c", epc_o); end
        @(negedge clk_i);
        do_mret(32'h100);
        checks++; if (redirect_o !== 1'b1) begin failures++; $display("FAIL hdl_ret_redirect got=%b exp=1", redirect_o); end
        checks++; if (redirect_pc_o !== 32'h100) begin failures++; $display("FAIL hdl_ret_pc got=%h exp=100", redirect_pc_o); end
        checks++; if (gie_o !== 1'b1) begin failures++; $display("FAIL hdl_ret_gie got=%b exp=1", gie_o); end
        wait_trap(6, n);
        checks++; if (n != 3 || mcause_o !== 32'h8000_0010) begin failures++; $display("FAIL hdl_retrap got=%0d/%h exp=3/80000010", n, mcause_o); end
        irq_i = '0;
    endtask

    task automatic test_mret_idle();
        do_reset();
        mret_i = 1'b1; mepc_i = 32'h55;
        @(negedge clk_i);
        mret_i = 1'b0;
        checks++; if (redirect_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL mret_idle got=%b%b exp=00", redirect_o, busy_o); end
    endtask

    task automatic test_edge_pulse();
        int n;
        do_reset();
        mie_i = 32'hFFFF_0000; mtvec_i = 32'h0000_4000;
        irq_i = 16'h0200;
        wait_trap(8, n);
        irq_i = '0;
        @(negedge clk_i);
        irq_i = 16'h0010;
        @(negedge clk_i);
        irq_i = '0;
        do_mret(32'h300);
        checks++; if (redirect_pc_o !== 32'h300) begin failures++; $display("FAIL pulse_ret got=%h exp=300", redirect_pc_o); end
        wait_trap(6, n);
        if (EDGE) begin
            checks++; if (n != 3 || mcause_o !== 32'h8000_0014) begin failures++; $display("FAIL pulse_edge got=%0d/%h exp=3/80000014", n, mcause_o); end
        end else begin
            checks++; if (n != -1) begin failures++; $display("FAIL pulse_level got=%0d exp=-1", n); end
        end
    endtask

    task automatic test_reset_async();
        int n;
        bit bad;
        do_reset();
        mie_i = 32'hFFFF_0000; ready_i = 1'b0;
        irq_i = 16'h0040;
        repeat (3) @(negedge clk_i);
        #2 rst_i = 1'b0;
        #1;
        checks++; if (busy_o !== 1'b0 || trap_o !== 1'b0) begin failures++; $display("FAIL arst_arm got=%b%b exp=00", busy_o, trap_o); end
        irq_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1; ready_i = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            if (trap_o !== 1'b0 || busy_o !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad) begin failures++; $display("FAIL arst_discard got=trap exp=none"); end
        irq_i = 16'h0040;
        wait_trap(8, n);
        checks++; if (n != LAT) begin failures++; $display("FAIL arst_relatch got=%0d exp=%0d", n, LAT); end
        #2 rst_i = 1'b0;
        #1;
        checks++; if (trap_o !== 1'b0 || redirect_o !== 1'b0 || irq_ack_o !== 16'h0) begin failures++; $display("FAIL arst_trap got=%b%b%h exp=000000", trap_o, redirect_o, irq_ack_o); end
        checks++; if (gie_o !== 1'b1) begin failures++; $display("FAIL arst_gie got=%b exp=1", gie_o); end
        irq_i = '0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_random();
        int line, cnt, d, exp_arm;
        bit is_exc, bad, stalled;
        logic [15:0] irq;
        logic [31:0] mie, mtvec, pc1, pc2, exp_cause, exp_epc;
        logic [4:0] code;
        for (int it = 0; it < 40; it++) begin
            do_reset();
            irq = 16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535));
            mie = $urandom;
            mtvec = $urandom;
            pc1 = $urandom & 32'hFFFF_FFFC;
            pc2 = $urandom & 32'hFFFF_FFFC;
            is_exc = ($urandom_range(0, 3) == 0);
            code = 5'($urandom_range(0, 31));
            d = $urandom_range(0, 3);
            line = model_pick(irq, mie);
            mie_i = mie; mtvec_i = mtvec; pc_i = pc1; ready_i = 1'b0;
            irq_i = irq; exc_i = is_exc; exc_cause_i = code;
            if (!is_exc && line < 0) begin
                bad = 1'b0;
                repeat (6) begin
                    @(negedge clk_i);
                    if (busy_o !== 1'b0 || trap_o !== 1'b0) bad = 1'b1;
                end
                checks++; if (bad) begin failures++; $display("FAIL rnd_idle it=%0d got=busy exp=idle", it); end
                continue;
            end
            cnt = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk_i);
                exc_i = 1'b0;
                cnt++;
                if (busy_o === 1'b1) break;
            end
            exp_arm = is_exc ? 1 : LAT - 1;
            checks++; if (cnt != exp_arm) begin failures++; $display("FAIL rnd_arm it=%0d got=%0d exp=%0d", it, cnt, exp_arm); end
            stalled = 1'b0;
            repeat (d) begin
                @(negedge clk_i);
                if (trap_o !== 1'b0) stalled = 1'b1;
            end
            ready_i = 1'b1; pc_i = pc2;
            @(negedge clk_i);
            exp_cause = is_exc ? {27'b0, code} : (32'h8000_0000 | 32'(16 + line));
            exp_epc = is_exc ? pc1 : pc2;
            checks++; if (trap_o !== 1'b1 || stalled) begin failures++; $display("FAIL rnd_trap it=%0d got=%b exp=1", it, trap_o); end
            checks++; if (mcause_o !== exp_cause) begin failures++; $display("FAIL rnd_mcause it=%0d got=%h exp=%h", it, mcause_o, exp_cause); end
            checks++; if (epc_o !== exp_epc) begin failures++; $display("FAIL rnd_epc it=%0d got=%h exp=%h", it, epc_o, exp_epc); end
            checks++; if (redirect_pc_o !== model_target(mtvec, is_exc, line)) begin failures++; $display("FAIL rnd_target it=%0d got=%h exp=%h", it, redirect_pc_o, model_target(mtvec, is_exc, line)); end
            checks++; if (irq_ack_o !== (is_exc ? 16'h0 : (16'h1 << line))) begin failures++; $display("FAIL rnd_ack it=%0d got=%h line=%0d", it, irq_ack_o, line); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic_irq();
        test_priority();
        test_exception();
        test_vectored_ready();
        test_handler();
        test_mret_idle();
        test_edge_pulse();
        test_reset_async();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
